// File: rtl/pio_clkdiv_sched.sv
// Per-state-machine clock-enable scheduler: INT.FRAC divisors with a carry accumulator,
// divisor changes deferred to period boundaries while running, and multi-SM restart.
module pio_clkdiv_lane #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              en_wr,
    input  logic              en_val,
    input  logic              cfg_wr,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              tick,
    output logic              enabled,
    output logic              cfg_pending
);
    logic              en, pend, en_eff;
    logic [INT_W-1:0]  act_int, pend_int;
    logic [FRAC_W-1:0] act_frac, pend_frac, acc;
    logic [INT_W:0]    cnt, eff_int, reload;
    logic [FRAC_W:0]   sum;

    // An en_wr takes effect in the cycle it is presented, so the first tick
    // of a freshly enabled SM appears on the following cycle.
    assign en_eff  = en_wr ? en_val : en;
    assign eff_int = (act_int == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, act_int};
    assign sum     = {1'b0, acc} + {1'b0, act_frac};
    assign reload  = eff_int - (INT_W+1)'(1) + (INT_W+1)'(sum[FRAC_W]);

    assign enabled     = en;
    assign cfg_pending = pend;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en        <= 1'b0;
            act_int   <= INT_W'(1);
            act_frac  <= '0;
            pend_int  <= '0;
            pend_frac <= '0;
            pend      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            tick      <= 1'b0;
        end else begin
            if (en_wr)
                en <= en_val;

            if (restart) begin
                cnt  <= '0;
                acc  <= '0;
                tick <= 1'b0;
                if (pend) begin
                    act_int  <= pend_int;
                    act_frac <= pend_frac;
                    pend     <= 1'b0;
                end
            end else if (!en_eff) begin
                tick <= 1'b0;
            end else if (cnt == '0) begin
                // Reload from the divisor active before this boundary; a pending
                // divisor only governs the period after the one loaded here.
                tick <= 1'b1;
                acc  <= sum[FRAC_W-1:0];
                cnt  <= reload;
                if (pend) begin
                    act_int  <= pend_int;
                    act_frac <= pend_frac;
                    pend     <= 1'b0;
                end
            end else begin
                cnt  <= cnt - (INT_W+1)'(1);
                tick <= 1'b0;
            end

            // A stopped SM cannot hit a boundary, so it takes the divisor at once;
            // a running one shadows it (a write on a boundary cycle lands here too).
            if (cfg_wr) begin
                if (!en_eff) begin
                    act_int  <= cfg_int;
                    act_frac <= cfg_frac;
                end else begin
                    pend_int  <= cfg_int;
                    pend_frac <= cfg_frac;
                    pend      <= 1'b1;
                end
            end
        end
    end
endmodule

module pio_clkdiv_sched #(
    parameter int NUM_SM = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8,
    parameter int SM_W   = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_wr,
    input  logic [SM_W-1:0]   cfg_sm,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              en_wr,
    input  logic [NUM_SM-1:0] en_mask,
    input  logic [NUM_SM-1:0] restart,
    output logic [NUM_SM-1:0] tick,
    output logic [NUM_SM-1:0] enabled,
    output logic [NUM_SM-1:0] cfg_pending
);
    // An out-of-range cfg_sm matches no lane, so the write is dropped.
    for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
        pio_clkdiv_lane #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_lane (
            .clock      (clock),
            .reset_n    (reset_n),
            .restart    (restart[i]),
            .en_wr      (en_wr),
            .en_val     (en_mask[i]),
            .cfg_wr     (cfg_wr && (cfg_sm == SM_W'(i))),
            .cfg_int    (cfg_int),
            .cfg_frac   (cfg_frac),
            .tick       (tick[i]),
            .enabled    (enabled[i]),
            .cfg_pending(cfg_pending[i])
        );
    end
endmodule

// File: tb/tb_pio_clkdiv_sched.sv
// Directed bench for pio_clkdiv_sched: divisor spacing, fractional carry, restart sync,
// deferred divisor updates, disable/resume and async reset.
module tb_pio_clkdiv_sched;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_sm = '0;
    logic [15:0] cfg_int = '0;
    logic [7:0]  cfg_frac = '0;
    logic        en_wr = 1'b0;
    logic [3:0]  en_mask = '0;
    logic [3:0]  restart = '0;
    logic [3:0]  tick, enabled, cfg_pending;

    int vecs = 0;
    int errs = 0;
    int n, g, t, ticks, first0, first2;

    pio_clkdiv_sched dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_wr     (cfg_wr),
        .cfg_sm     (cfg_sm),
        .cfg_int    (cfg_int),
        .cfg_frac   (cfg_frac),
        .en_wr      (en_wr),
        .en_mask    (en_mask),
        .restart    (restart),
        .tick       (tick),
        .enabled    (enabled),
        .cfg_pending(cfg_pending)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_w(input logic [1:0] sm, input logic [15:0] di, input logic [7:0] df);
        cfg_wr = 1'b1; cfg_sm = sm; cfg_int = di; cfg_frac = df;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic set_en(input logic [3:0] m);
        en_wr = 1'b1; en_mask = m;
        step();
        en_wr = 1'b0;
    endtask

    // Cycles until the next tick of one SM; a bound overrun shows up as a wrong gap.
    task automatic wait_tick(input int sm, input int limit, output int gap);
        gap = 0;
        do begin
            step();
            gap++;
        end while (tick[sm] !== 1'b1 && gap < limit);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_enabled", 32'(enabled), 0);
        chk("rst_pending", 32'(cfg_pending), 0);
        reset_n = 1'b1;
        step();

        // Divisor 1.0 (reset value) on SM0: a tick every cycle
        set_en(4'b0001);
        n = 0;
        for (int k = 0; k < 20; k++) begin n += int'(tick[0]); step(); end
        chk("div1_20ticks", 32'(n), 20);
        set_en(4'b0000);
        chk("div1_off", 32'(tick[0]), 0);

        // Divisor 3.0 on SM1: 100-cycle window from the first tick holds 34 ticks
        cfg_w(2'd1, 16'd3, 8'd0);
        chk("div3_direct_nopend", 32'(cfg_pending), 0);
        set_en(4'b0010);
        n = 0;
        for (int k = 0; k < 100; k++) begin n += int'(tick[1]); step(); end
        chk("div3_100win", 32'(n), 34);

        // Divisor 2.5 on SM2: ticks at 1,3,6,8,11,13,16,18,21,23
        cfg_w(2'd2, 16'd2, 8'd128);
        set_en(4'b0100);
        t = 1; ticks = 0;
        while (t < 60) begin
            if (tick[2]) begin
                ticks++;
                if (ticks == 10) break;
            end
            step();
            t++;
        end
        chk("div2p5_10ticks_span", 32'(t), 23);
        set_en(4'b0000);

        // Phase sync: SM0 div 4, SM2 div 7 started at different times
        cfg_w(2'd0, 16'd4, 8'd0);
        cfg_w(2'd2, 16'd7, 8'd0);
        set_en(4'b0001);
        step(); step();
        set_en(4'b0101);
        step(); step(); step();
        restart = 4'b0101;
        step();
        restart = 4'b0000;
        chk("sync_clear", 32'(tick & 4'b0101), 0);
        step();
        chk("sync_together", 32'(tick & 4'b0101), 32'b0101);
        first0 = 0; first2 = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick[0] && first0 == 0) first0 = k;
            if (tick[2] && first2 == 0) first2 = k;
        end
        chk("sync_gap_sm0", 32'(first0), 4);
        chk("sync_gap_sm2", 32'(first2), 7);

        // Running update on SM0 (div 5); restart and enable presented together
        set_en(4'b0000);
        cfg_w(2'd0, 16'd5, 8'd0);
        restart = 4'b0001; en_wr = 1'b1; en_mask = 4'b0001;
        step();
        restart = 4'b0000; en_wr = 1'b0;
        chk("upd_restart_tick", 32'(tick[0]), 0);
        chk("upd_restart_en", 32'(enabled), 32'b0001);
        step();
        chk("upd_first_tick", 32'(tick[0]), 1);
        step();
        cfg_w(2'd0, 16'd2, 8'd0);
        chk("upd_pending_set", 32'(cfg_pending), 32'b0001);
        wait_tick(0, 20, g);
        chk("upd_gap_rest_of_5", 32'(g), 3);
        chk("upd_pending_clr", 32'(cfg_pending), 0);
        wait_tick(0, 20, g);
        chk("upd_gap_still_5", 32'(g), 5);
        wait_tick(0, 20, g);
        chk("upd_gap_2a", 32'(g), 2);
        wait_tick(0, 20, g);
        chk("upd_gap_2b", 32'(g), 2);

        // Back-to-back writes on SM1 (div 5): the second write (9) wins
        cfg_w(2'd1, 16'd5, 8'd0);
        restart = 4'b0010; en_wr = 1'b1; en_mask = 4'b0011;
        step();
        restart = 4'b0000; en_wr = 1'b0;
        chk("b2b_restart_tick", 32'(tick[1]), 0);
        step();
        chk("b2b_first_tick", 32'(tick[1]), 1);
        step();
        cfg_w(2'd1, 16'd3, 8'd0);
        cfg_w(2'd1, 16'd9, 8'd0);
        chk("b2b_pending", 32'(cfg_pending[1]), 1);
        wait_tick(1, 20, g);
        chk("b2b_gap_rest_of_5", 32'(g), 2);
        chk("b2b_pending_clr", 32'(cfg_pending[1]), 0);
        wait_tick(1, 20, g);
        chk("b2b_gap_still_5", 32'(g), 5);
        wait_tick(1, 20, g);
        chk("b2b_gap_9", 32'(g), 9);

        // Disable SM1 for 10 cycles after 3 counted cycles; 5 remain on resume
        step(); step(); step();
        en_wr = 1'b1; en_mask = 4'b0001;
        n = 0;
        for (int k = 0; k < 10; k++) begin step(); en_wr = 1'b0; n += int'(tick[1]); end
        chk("dis_no_ticks", 32'(n), 0);
        chk("dis_enabled", 32'(enabled), 32'b0001);
        set_en(4'b0011);
        chk("dis_resume_no_tick", 32'(tick[1]), 0);
        wait_tick(1, 20, g);
        chk("dis_resume_gap", 32'(g), 5);

        // Async reset while SM1's tick is high
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tick", 32'(tick), 0);
        chk("arst_enabled", 32'(enabled), 0);
        chk("arst_pending", 32'(cfg_pending), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        set_en(4'b0001);
        n = 0;
        for (int k = 0; k < 5; k++) begin n += int'(tick[0]); step(); end
        chk("arst_div1_restored", 32'(n), 5);
        set_en(4'b0000);

        // Integer field 0 means 2^16
        cfg_w(2'd3, 16'd0, 8'd0);
        set_en(4'b1000);
        chk("int0_first_tick", 32'(tick[3]), 1);
        wait_tick(3, 70000, g);
        chk("int0_gap_65536", 32'(g), 65536);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
